codec_tx: RTL and testbench

//  Transmit side of the stereo codec link: serializes EQ-processed lft/rht samples to the DAC as I2S.

---
 rtl/codec_pkg.sv | 20 ++
 rtl/codec_tx_clk_gen.sv | 39 +++
 rtl/codec_tx.sv | 91 +++++++++
 tb/tb_codec_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared stereo codec link types and timing constants.
// Used by both the transmit and receive paths.
package codec_pkg;

  localparam int SMPL_W   = 16;
  localparam int CNT_W    = 10;
  localparam int MCLK_BIT = 1;
  localparam int SCLK_BIT = 4;
  localparam int SLOT_W   = CNT_W - SCLK_BIT - 1;
  localparam int FRM_W    = 2 * SMPL_W;

  // Slot whose closing SCLK fall loads the shifter.
  localparam int LOAD_SLOT = 0;

  typedef struct packed {
    logic signed [SMPL_W-1:0] lft;
    logic signed [SMPL_W-1:0] rht;
  } stereo_smpl_t;

endpackage

// File: rtl/codec_tx_clk_gen.sv
// Frame counter and registered MCLK/SCLK/LRCLK for the I2S link.
// Also produces the SCLK-fall and shifter-load strobes.
module codec_clk_gen
  import codec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic mclk,
  output logic sclk,
  output logic lrclk,
  output logic sclk_fall,
  output logic load_event
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt + CNT_W'(1);

  // Clock pins track the counter bits exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mclk  <= 1'b0;
      sclk  <= 1'b0;
      lrclk <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      mclk  <= cnt_nxt[MCLK_BIT];
      sclk  <= cnt_nxt[SCLK_BIT];
      lrclk <= cnt_nxt[CNT_W-1];
    end
  end

  assign sclk_fall  = &cnt[SCLK_BIT:0];
  assign load_event = sclk_fall &&
    (cnt[CNT_W-1:SCLK_BIT+1] == SLOT_W'(LOAD_SLOT));

endmodule

// File: rtl/codec_tx.sv
// I2S transmitter: one-pair hold buffer, MSB-first shifter, underflow flag.
// CODEC_TX_UFLOW_MUTE_EN: underflow sends silence instead of the last pair.
module codec_tx
  import codec_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SMPL_W-1:0] lft_in,
  input  logic signed [SMPL_W-1:0] rht_in,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic                     MCLK,
  output logic                     SCLK,
  output logic                     LRCLK,
  output logic                     SDout,
  output logic                     smpl_req,
  output logic                     uflow
);

  stereo_smpl_t     hold;
  stereo_smpl_t     in_pair;
  stereo_smpl_t     rpt;
  logic             hold_full;
  logic             run;
  logic             xfer;
  logic             sclk_fall;
  logic             load_event;
  logic [FRM_W-1:0] shreg;

  codec_clk_gen u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .mclk       (MCLK),
    .sclk       (SCLK),
    .lrclk      (LRCLK),
    .sclk_fall  (sclk_fall),
    .load_event (load_event)
  );

  assign in_pair  = {lft_in, rht_in};
  assign in_rdy   = run & (~hold_full | load_event);
  assign xfer     = in_vld & in_rdy;
  assign smpl_req = load_event;
  assign SDout    = shreg[FRM_W-1];

`ifdef CODEC_TX_UFLOW_MUTE_EN
  assign rpt = '0;
`else
  stereo_smpl_t last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= '0;
    end else if (load_event && hold_full) begin
      last <= hold;
    end
  end

  assign rpt = last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      run       <= 1'b0;
      hold_full <= 1'b0;
      hold      <= '0;
      shreg     <= '0;
      uflow     <= 1'b0;
    end else begin
      run <= 1'b1;
      // A transfer on the load cycle refills the slot being drained.
      if (xfer) begin
        hold      <= in_pair;
        hold_full <= 1'b1;
      end else if (load_event) begin
        hold_full <= 1'b0;
      end
      if (load_event) begin
        if (hold_full) begin
          shreg <= hold;
        end else begin
          shreg <= rpt;
          uflow <= 1'b1;
        end
      end else if (sclk_fall) begin
        shreg <= {shreg[FRM_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_codec_tx.sv
// Directed bench for codec_tx: frame capture, handshake, underflow.
// Build with CODEC_TX_UFLOW_MUTE_EN to check the muted variant.
module tb_codec_tx;

  logic        clk;
  logic        rst;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        in_vld;
  logic        in_rdy;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        SDout;
  logic        smpl_req;
  logic        uflow;

  int          n_vec;
  int          n_err;
  int          cyc;
  int          acc;
  logic [31:0] drv_w;

  codec_tx dut (
    .clk      (clk),
    .rst      (rst),
    .lft_in   (lft_in),
    .rht_in   (rht_in),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .MCLK     (MCLK),
    .SCLK     (SCLK),
    .LRCLK    (LRCLK),
    .SDout    (SDout),
    .smpl_req (smpl_req),
    .uflow    (uflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench copy of the frame position.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      if ((cyc % 1024) == v) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_cnt", 32'(hit), 32'd1);
  endtask

  task automatic send(input logic [15:0] l,
                      input logic [15:0] r);
    logic ok;
    ok     = 1'b0;
    lft_in = l;
    rht_in = r;
    in_vld = 1'b1;
    for (int i = 0; i < 2100; i++) begin
      if (in_rdy) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_vld = 1'b0;
    chk("send", 32'(ok), 32'd1);
  endtask

  // Samples mid-slot (SCLK high): slots 1..31, then slot 0 of next frame.
  task automatic get_frame(input string tag,
                           input logic [31:0] exp);
    logic [31:0] bits;
    int          slot;
    wait_cnt(52);
    for (int s = 0; s < 32; s++) begin
      if (s > 0) repeat (32) tick();
      slot       = (s + 1) % 32;
      bits[31-s] = SDout;
      chk("sclk_hi", 32'(SCLK), 32'd1);
      chk("lrclk", 32'(LRCLK), (slot >= 16) ? 32'd1 : 32'd0);
    end
    chk(tag, bits, exp);
  endtask

  function automatic logic [31:0] qp(input int k);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'h1230 + 16'(k);
    b = 16'hFED0 + 16'(k);
    return {a, b};
  endfunction

  task automatic chk_rst_outs(input string tag);
    chk(tag, 32'({MCLK, SCLK, LRCLK, SDout,
                  in_rdy, smpl_req, uflow}), 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    acc    = 0;
    rst    = 1'b1;
    in_vld = 1'b0;
    lft_in = '0;
    rht_in = '0;
    repeat (3) tick();
    chk_rst_outs("rst_init");
    rst = 1'b0;
    tick();
    chk("rdy_rel", 32'(in_rdy), 32'd1);

    send(16'hA5C3, 16'h0F0F);
    wait_cnt(15);
    chk("sclk15", 32'(SCLK), 32'd0);
    chk("mclk15", 32'(MCLK), 32'd1);
    tick();
    chk("sclk16", 32'(SCLK), 32'd1);
    chk("mclk16", 32'(MCLK), 32'd0);
    wait_cnt(31);
    chk("req_ld", 32'(smpl_req), 32'd1);
    tick();
    chk("req_off", 32'(smpl_req), 32'd0);
    chk("uf0", 32'(uflow), 32'd0);
    send(16'h8000, 16'h7FFF);
    get_frame("frm_a5c3", 32'hA5C3_0F0F);
    get_frame("frm_fs", 32'h8000_7FFF);

    send(16'h1111, 16'h2222);
    wait_cnt(32);
    send(16'h3333, 16'h4444);
    repeat (3) tick();
    chk("rdy_full", 32'(in_rdy), 32'd0);
    get_frame("frm_p1", 32'h1111_2222);
    wait_cnt(31);
    chk("rdy_ld", 32'(in_rdy), 32'd1);
    lft_in = 16'h5555;
    rht_in = 16'h6666;
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    chk("rdy_held", 32'(in_rdy), 32'd0);
    get_frame("frm_p2", 32'h3333_4444);
    get_frame("frm_p3", 32'h5555_6666);
    chk("uf_simul", 32'(uflow), 32'd0);

    fork
      begin
        for (int i = 0; i < 3072; i++) begin
          drv_w  = qp(acc);
          lft_in = drv_w[31:16];
          rht_in = drv_w[15:0];
          in_vld = 1'b1;
          if (i == 5) chk("strm_rdy", 32'(in_rdy), 32'd0);
          if (in_rdy) acc++;
          tick();
        end
        in_vld = 1'b0;
        chk("strm_acc", 32'(acc), 32'd4);
      end
      begin
        get_frame("strm0", qp(0));
        get_frame("strm1", qp(1));
        get_frame("strm2", qp(2));
      end
    join
    get_frame("strm3", qp(3));
    chk("uf_strm", 32'(uflow), 32'd0);

    wait_cnt(100);
    rst = 1'b1;
    tick();
    chk_rst_outs("rst_mid");
    repeat (2) tick();
    chk_rst_outs("rst_mid3");
    rst = 1'b0;
    tick();
    chk("rdy_rel2", 32'(in_rdy), 32'd1);
    send(16'hA5C3, 16'h0F0F);
    get_frame("frm_b1", 32'hA5C3_0F0F);
    chk("uf_b1", 32'(uflow), 32'd0);
`ifdef CODEC_TX_UFLOW_MUTE_EN
    get_frame("frm_uf", 32'h0000_0000);
`else
    get_frame("frm_uf", 32'hA5C3_0F0F);
`endif
    chk("uf_set", 32'(uflow), 32'd1);
    wait_cnt(511);
    chk("lr511", 32'(LRCLK), 32'd0);
    tick();
    chk("lr512", 32'(LRCLK), 32'd1);
    chk("uf_stky", 32'(uflow), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
